// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: event kinds and entry field layout.
// No logic; constants only.
// Entry layout is {kind, addr, data, seq} with seq width chosen by the instantiating block.
package trace_pkg;
   localparam logic [1:0] TRACE_KIND_PC  = 2'b01;
   localparam logic [1:0] TRACE_KIND_REG = 2'b10;

   localparam int KIND_W = 2;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   // Width of the fixed-size part of an entry; the seq field is appended below it.
   localparam int ENTRY_FIXED_W = KIND_W + ADDR_W + DATA_W;
endpackage

// File: rtl/trace_ram_2w1r.sv
// Storage array for trace entries: two write ports, one asynchronous read port.
// Writes land on the rising edge; read data follows the read address combinationally.
// No flow control here; the owning block guarantees distinct write addresses.
module trace_ram_2w1r #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     we0,
   input  logic [$clog2(DEPTH)-1:0] wa0,
   input  logic [W-1:0]             wd0,
   input  logic                     we1,
   input  logic [$clog2(DEPTH)-1:0] wa1,
   input  logic [W-1:0]             wd1,
   input  logic [$clog2(DEPTH)-1:0] ra,
   output logic [W-1:0]             rd
);
   logic [W-1:0] mem [DEPTH];

   // Port 1 is written first so that port 0 takes precedence on any address collision.
   always_ff @(posedge clk) begin
      if (we1) mem[wa1] <= wd1;
      if (we0) mem[wa0] <= wd0;
   end

   assign rd = mem[ra];
endmodule

// File: rtl/commit_trace_buffer.sv
// Captures PC-load and register-write commit events with sequence numbers into a FIFO.
// Latency: an event sampled at edge N appears at the head after edge N when the FIFO was empty.
// Backpressure: first-word-fall-through valid/ready drain; events with no free slot are dropped and counted.
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int SEQ_W  = 16,
   parameter int DROP_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       pc_load,
   input  logic [31:0]                pc_value,
   input  logic                       rf_write,
   input  logic [4:0]                 rf_addr,
   input  logic [31:0]                rf_data,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [1:0]                 trace_kind,
   output logic [4:0]                 trace_addr,
   output logic [31:0]                trace_data,
   output logic [SEQ_W-1:0]           trace_seq,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow,
   output logic [DROP_W-1:0]          drop_count
);
   localparam int AW      = $clog2(DEPTH);
   localparam int CNT_W   = AW + 1;
   localparam int ENTRY_W = ENTRY_FIXED_W + SEQ_W;

   typedef struct packed {
      logic [KIND_W-1:0] kind;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [SEQ_W-1:0]  seq;
   } entry_t;

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [SEQ_W-1:0]  seq;

   logic              pc_ev;
   logic              reg_ev;
   logic [1:0]        n_ev;
   logic [1:0]        n_acc;
   logic [1:0]        n_drop;
   logic [CNT_W-1:0]  free;
   logic              acc0;
   logic              acc1;
   logic              pop;
   entry_t            ev0;
   entry_t            ev1;
   entry_t            head;
   logic [ENTRY_W-1:0] rd_dat;
   logic [DROP_W:0]   drop_sum;
   logic [DROP_W-1:0] drop_next;

   // Event decode, slot allocation against start-of-cycle space, and entry assembly.
   always_comb begin
      pc_ev  = pc_load;
      reg_ev = rf_write && (rf_addr != '0);
      n_ev   = {1'b0, pc_ev} + {1'b0, reg_ev};
      // A same-cycle pop does not free a slot for this cycle's pushes.
      free   = CNT_W'(DEPTH) - count;
      acc0   = (n_ev != 2'd0) && (free != '0);
      acc1   = (n_ev == 2'd2) && (free >= CNT_W'(2));
      n_acc  = {1'b0, acc0} + {1'b0, acc1};
      n_drop = n_ev - n_acc;
      pop    = trace_valid && trace_ready;

      // First event is the PC event when present, otherwise the register event.
      ev0 = '0;
      if (pc_ev) begin
         ev0.kind = TRACE_KIND_PC;
         ev0.addr = '0;
         ev0.data = pc_value;
      end else begin
         ev0.kind = TRACE_KIND_REG;
         ev0.addr = rf_addr;
         ev0.data = rf_data;
      end
      ev0.seq = seq;

      // A second event only exists when both fire, and it is always the register event.
      ev1      = '0;
      ev1.kind = TRACE_KIND_REG;
      ev1.addr = rf_addr;
      ev1.data = rf_data;
      ev1.seq  = seq + SEQ_W'(1);

      drop_sum  = {1'b0, drop_count} + (DROP_W+1)'(n_drop);
      drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
   end

   trace_ram_2w1r #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_ram (
      .clk (clk),
      .we0 (acc0 && !clear),
      .wa0 (wr_ptr),
      .wd0 (ev0),
      .we1 (acc1 && !clear),
      .wa1 (wr_ptr + AW'(1)),
      .wd1 (ev1),
      .ra  (rd_ptr),
      .rd  (rd_dat)
   );

   // Pointer, occupancy, sequence and drop bookkeeping; clear discards the cycle's events uncounted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         seq        <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         seq        <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         wr_ptr     <= wr_ptr + AW'(n_acc);
         rd_ptr     <= rd_ptr + AW'(pop);
         count      <= count + CNT_W'(n_acc) - CNT_W'(pop);
         seq        <= seq + SEQ_W'(n_ev);
         drop_count <= drop_next;
         if (n_drop != 2'd0) overflow <= 1'b1;
      end
   end

   // Head fields are zeroed whenever nothing is valid so stale array contents never leak out.
   always_comb begin
      head        = entry_t'(rd_dat);
      trace_valid = (count != '0);
      trace_kind  = trace_valid ? head.kind : '0;
      trace_addr  = trace_valid ? head.addr : '0;
      trace_data  = trace_valid ? head.data : '0;
      trace_seq   = trace_valid ? head.seq  : '0;
      fifo_count  = count;
   end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus random traffic
// against a queue-based reference model of the event/drop/sequence rules.
module tb_commit_trace_buffer;
   localparam int DEPTH  = 16;
   localparam int SEQ_W  = 16;
   localparam int DROP_W = 16;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              clear;
   logic              pc_load;
   logic [31:0]       pc_value;
   logic              rf_write;
   logic [4:0]        rf_addr;
   logic [31:0]       rf_data;
   logic              trace_valid;
   logic              trace_ready;
   logic [1:0]        trace_kind;
   logic [4:0]        trace_addr;
   logic [31:0]       trace_data;
   logic [SEQ_W-1:0]  trace_seq;
   logic [CNT_W-1:0]  fifo_count;
   logic              overflow;
   logic [DROP_W-1:0] drop_count;

   commit_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .pc_load     (pc_load),
      .pc_value    (pc_value),
      .rf_write    (rf_write),
      .rf_addr     (rf_addr),
      .rf_data     (rf_data),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .trace_kind  (trace_kind),
      .trace_addr  (trace_addr),
      .trace_data  (trace_data),
      .trace_seq   (trace_seq),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  kind;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [15:0] seq;
   } ev_t;

   ev_t         mq[$];
   int unsigned m_seq;
   int unsigned m_drop;
   bit          m_ovf;
   int          m_free;
   int          n_checks = 0;
   int          n_bad    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_seq  = 0;
      m_drop = 0;
      m_ovf  = 0;
   endtask

   task automatic take_event(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      e.seq  = 16'(m_seq);
      if (m_free > 0) begin
         mq.push_back(e);
         m_free--;
      end else begin
         m_ovf = 1;
         if (m_drop < 65535) m_drop++;
      end
      m_seq = (m_seq + 1) % 65536;
   endtask

   // Applies one rising edge worth of behaviour using the inputs present at that edge.
   task automatic model_edge();
      if (clear) begin
         model_reset();
      end else begin
         m_free = DEPTH - mq.size();
         if (mq.size() != 0 && trace_ready) void'(mq.pop_front());
         if (pc_load) take_event(2'b01, 5'd0, pc_value);
         if (rf_write && rf_addr != 5'd0) take_event(2'b10, rf_addr, rf_data);
      end
   endtask

   task automatic compare_all(input string tag);
      ev_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      check({tag, ".valid"}, 64'(trace_valid), 64'(mq.size() != 0));
      check({tag, ".kind"},  64'(trace_kind),  64'(h.kind));
      check({tag, ".addr"},  64'(trace_addr),  64'(h.addr));
      check({tag, ".data"},  64'(trace_data),  64'(h.data));
      check({tag, ".seq"},   64'(trace_seq),   64'(h.seq));
      check({tag, ".count"}, 64'(fifo_count),  64'(mq.size()));
      check({tag, ".ovf"},   64'(overflow),    64'(m_ovf));
      check({tag, ".drop"},  64'(drop_count),  64'(m_drop));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic drive(input logic pl, input logic [31:0] pv, input logic rw,
                        input logic [4:0] ra, input logic [31:0] rd, input logic rdy);
      pc_load     = pl;
      pc_value    = pv;
      rf_write    = rw;
      rf_addr     = ra;
      rf_data     = rd;
      trace_ready = rdy;
   endtask

   task automatic do_clear();
      clear = 1;
      drive(0, 0, 0, 0, 0, 0);
      step("clr");
      clear = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0;
      clear = 0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      compare_all("rst");
      reset = 1;

      // 1: single PC event, one-cycle latency
      drive(1, 32'h4, 0, 0, 0, 0);
      step("t1");
      drive(0, 0, 0, 0, 0, 0);
      check("t1.valid_c", 64'(trace_valid), 64'd1);
      check("t1.kind_c",  64'(trace_kind),  64'd1);
      check("t1.data_c",  64'(trace_data),  64'h4);
      check("t1.seq_c",   64'(trace_seq),   64'd0);
      check("t1.cnt_c",   64'(fifo_count),  64'd1);
      do_clear();

      // 2: simultaneous PC and REG events keep PC first
      drive(1, 32'h8, 1, 5'd9, 32'hDEADBEEF, 0);
      step("t2");
      drive(0, 0, 0, 0, 0, 0);
      check("t2.cnt_c",   64'(fifo_count), 64'd2);
      check("t2.kind0_c", 64'(trace_kind), 64'd1);
      check("t2.data0_c", 64'(trace_data), 64'h8);
      trace_ready = 1;
      step("t2pop");
      check("t2.kind1_c", 64'(trace_kind), 64'd2);
      check("t2.addr1_c", 64'(trace_addr), 64'd9);
      check("t2.data1_c", 64'(trace_data), 64'hDEADBEEF);
      check("t2.seq1_c",  64'(trace_seq),  64'd1);
      step("t2pop2");
      check("t2.empty_c", 64'(trace_valid), 64'd0);
      do_clear();

      // 3: writes to r0 are invisible
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 1, 5'd0, $urandom, 0);
         step("t3");
      end
      check("t3.cnt_c", 64'(fifo_count), 64'd0);
      drive(1, 32'h100, 0, 0, 0, 0);
      step("t3pc");
      check("t3.seq_c", 64'(trace_seq), 64'd0);
      check("t3.ovf_c", 64'(overflow),  64'd0);
      do_clear();

      // 4: overfill by three, drain, next seq exposes the gap
      for (int i = 0; i < DEPTH + 3; i++) begin
         drive(1, 32'(i * 4), 0, 0, 0, 0);
         step("t4fill");
      end
      check("t4.cnt_c",  64'(fifo_count), 64'd16);
      check("t4.ovf_c",  64'(overflow),   64'd1);
      check("t4.drop_c", 64'(drop_count), 64'd3);
      for (int i = 0; i < DEPTH; i++) begin
         check("t4.drain_seq_c", 64'(trace_seq), 64'(i));
         drive(0, 0, 0, 0, 0, 1);
         step("t4drain");
      end
      drive(1, 32'h40, 0, 0, 0, 0);
      step("t4next");
      check("t4.next_seq_c", 64'(trace_seq), 64'd19);
      do_clear();

      // 5: one free slot, dual event, simultaneous pop
      for (int i = 0; i < DEPTH - 1; i++) begin
         drive(1, 32'(i), 0, 0, 0, 0);
         step("t5fill");
      end
      drive(1, 32'h55, 1, 5'd3, 32'h33, 1);
      step("t5dual");
      check("t5.cnt_c",  64'(fifo_count), 64'd15);
      check("t5.drop_c", 64'(drop_count), 64'd1);
      check("t5.ovf_c",  64'(overflow),   64'd1);
      do_clear();

      // 6: async reset mid-drain, then clear with same-cycle events
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'(i + 100), 0, 0, 0, 0);
         step("t6fill");
      end
      drive(0, 0, 0, 0, 0, 1);
      step("t6drain");
      step("t6drain");
      #2;
      reset = 0;
      model_reset();
      #1;
      compare_all("t6rst");
      check("t6.valid_c", 64'(trace_valid), 64'd0);
      check("t6.data_c",  64'(trace_data),  64'd0);
      check("t6.cnt_c",   64'(fifo_count),  64'd0);
      drive(1, 32'h77, 1, 5'd4, 32'h44, 0);
      step("t6held");
      reset = 1;
      clear = 1;
      drive(1, 32'h88, 1, 5'd5, 32'h55, 0);
      step("t6clr");
      clear = 0;
      check("t6.clr_cnt_c", 64'(fifo_count), 64'd0);
      drive(1, 32'h99, 0, 0, 0, 0);
      step("t6after");
      check("t6.seq0_c", 64'(trace_seq), 64'd0);
      do_clear();

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         clear = ($urandom_range(0, 59) == 0);
         drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
               5'($urandom_range(0, 31) < 6 ? 0 : $urandom_range(1, 31)), $urandom,
               $urandom_range(0, 2) == 0);
         step("rnd");
      end
      clear = 0;
      do_clear();

      // Long saturation run: drop counter saturates and seq wraps
      for (int i = 0; i < 32800; i++) begin
         drive(1, 32'(i), 1, 5'd7, 32'(~i), 0);
         step("sat");
      end
      check("sat.drop_c", 64'(drop_count), 64'hFFFF);
      check("sat.ovf_c",  64'(overflow),   64'd1);
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         step("satdrain");
      end
      drive(1, 32'hABC, 0, 0, 0, 0);
      step("satnext");
      check("sat.wrap_seq_c", 64'(trace_seq), 64'd64);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Downstream debug stage of the multicycle CPU. It captures architectural commit events every cycle:
- PC register loads (PC enable asserted, new PC value).
- Register-file writes (regwrite, destination, write data).

Events are buffered in a small FIFO with sequence numbers and drained through a valid/ready port to the bench or a debug UART. Dropped events are counted and flagged, never silently lost.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 4.
SEQ_W, 16, sequence-number width; wraps modulo 2^SEQ_W.
DROP_W, 16, drop-counter width; saturating.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
clear  in  1  synchronous clear of FIFO, counters and flags
pc_load  in  1  PC register write enable (PC_write OR taken-branch)
pc_value  in  32  value being loaded into PC
rf_write  in  1  register-file write enable
rf_addr  in  5  destination register number
rf_data  in  32  data written to register file
trace_valid  out  1  head entry available
trace_ready  in  1  consumer accepts head entry
trace_kind  out  2  01 = PC event, 10 = REG event
trace_addr  out  5  register number for REG events; 0 for PC events
trace_data  out  32  PC value or register data
trace_seq  out  SEQ_W  event sequence number
fifo_count  out  $clog2(DEPTH)+1  occupied entries
overflow  out  1  sticky: at least one event dropped
drop_count  out  DROP_W  number of dropped events, saturating

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty; pointers, fifo_count, seq counter, overflow and drop_count all 0. trace_valid=0 and all trace_* outputs are 0.
- Event generation, sampled each rising edge:
  - pc_load=1 produces a PC event.
  - rf_write=1 with rf_addr!=0 produces a REG event.
  - rf_write with rf_addr==0 is ignored entirely: no event, no seq increment, no drop.
- Simultaneous PC and REG events in one cycle: PC event is ordered first (seq=S), REG event second (seq=S+1). Up to 2 pushes per cycle.
- Sequence numbers: every generated event consumes one seq value, whether accepted or dropped, so gaps expose drops. Counter wraps from 2^SEQ_W-1 to 0.
- Space check: free = DEPTH - fifo_count at the start of the cycle. A pop in the same cycle does not create space for that cycle's pushes.
- Events are accepted in order while free slots remain; the rest are dropped:
  - with free=1 and two events, the PC event is stored and the REG event dropped.
- Each drop sets overflow=1 (sticky) and adds 1 to drop_count, saturating at all-ones. Two drops in one cycle add 2, still saturating.
- Output is first-word-fall-through. trace_valid = (fifo_count != 0).
- Pop occurs when trace_valid && trace_ready. trace_valid may drop on the following edge only if the FIFO becomes empty.
- When trace_valid=0, trace_kind, trace_addr, trace_data and trace_seq are forced to 0.
- Latency: an event sampled at edge N is visible at the outputs after edge N when the FIFO was empty (1 cycle).
- Count update: fifo_count_next = fifo_count + pushes - pop, where pushes is 0..2 and pop is 0..1.
- Pointers: read and write pointers wrap modulo DEPTH. Full and empty are derived from fifo_count, not from pointer equality.
- clear=1 priority: empties the FIFO and zeroes seq, overflow and drop_count. It overrides any pushes and pops in that cycle, and events in that cycle are discarded uncounted.
- Reset mid-stream: reset asserted at any time immediately returns the block to the reset state. In-flight events are lost and are not counted as drops.

Decomposition:
- Shared package trace_pkg holds:
  - kind constants TRACE_KIND_PC=2'b01 and TRACE_KIND_REG=2'b10;
  - entry field widths (kind 2, addr 5, data 32, seq SEQ_W);
  - packed entry layout {kind, addr, data, seq}.
- One sub-module, trace_ram_2w1r: a DEPTH-entry register array with two write ports (port 0 wins ordering; the two addresses are always distinct) and one asynchronous read port. All control logic stays in the top module.

Test Plan:
1. Reset then a single pc_load with pc_value=0x00000004, trace_ready=0 -> next cycle trace_valid=1, kind=01, data=0x4, seq=0, fifo_count=1.
2. Same cycle pc_load (0x8) and rf_write (addr 9, data 0xDEADBEEF) -> two entries in order: {01, 0, 0x8, seq 0} then {10, 9, 0xDEADBEEF, seq 1}; fifo_count=2.
3. rf_write with rf_addr=0 for 10 cycles -> no entries, seq stays 0, overflow=0.
4. trace_ready=0, DEPTH+3 single PC events -> fifo_count=16, overflow=1, drop_count=3. Draining then shows seq 0..15, and the next accepted event carries seq=19.
5. fifo_count=15 with a dual event and a simultaneous pop -> PC event stored, REG event dropped, drop_count+1, fifo_count stays 15.
6. FIFO half full, assert reset low mid-drain -> all outputs 0 asynchronously. With clear=1 and events in the same cycle, the next cycle shows fifo_count=0 and seq restarts at 0.
